// File: rtl/alu_op_decoder.sv
// ID-stage ALU control decoder: MIPS instr -> aluOp, operand selects, extended imm, one-entry ID/EX register.
// Latency 1 cycle; inReady = !outValid || outReady, so the held entry stalls input until EX consumes it.
// Backpressure: consume and accept in the same cycle replace the entry with no bubble. Optional ALU_DECODE_TRAP_EN flags illegal encodings on rsvdInstr.
module alu_op_decoder #(
    parameter logic [3:0] NOP_OP = 4'b1110
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] instr,
    output logic        outValid,
    input  logic        outReady,
    output logic [3:0]  aluOp,
    output logic        src1Shamt,
    output logic        src2Imm,
    output logic [31:0] imm,
    output logic [4:0]  destReg,
    output logic        regWrite,
    output logic        memRead,
    output logic        memWrite,
    output logic        rsvdInstr
);

    typedef struct packed {
        logic [3:0]  alu_op;
        logic        src1_shamt;
        logic        src2_imm;
        logic [31:0] imm;
        logic [4:0]  dest_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        rsvd;
    } entry_t;

    entry_t dec;
    entry_t held;
    logic   legal;
    logic   take;
    logic   unused_rs;

    wire [5:0]  op     = instr[31:26];
    wire [4:0]  rt     = instr[20:16];
    wire [4:0]  rd     = instr[15:11];
    wire [5:0]  funct  = instr[5:0];
    wire [31:0] imm_se = {{16{instr[15]}}, instr[15:0]};
    wire [31:0] imm_ze = {16'h0000, instr[15:0]};

    // rs only addresses the register file, which reads it straight from the fetch word.
    assign unused_rs = ^instr[25:21];

    always_comb begin
        dec        = '0;
        dec.alu_op = NOP_OP;
        legal      = 1'b1;
        if (op == 6'b000000) begin
            dec.dest_reg  = rd;
            dec.reg_write = 1'b1;
            case (funct)
                6'b100000: dec.alu_op = 4'b0000;
                6'b100001: dec.alu_op = 4'b0001;
                6'b100010: dec.alu_op = 4'b0010;
                6'b100011: dec.alu_op = 4'b0011;
                6'b100100: dec.alu_op = 4'b0110;
                6'b100101: dec.alu_op = 4'b1001;
                6'b100110: dec.alu_op = 4'b1010;
                6'b100111: dec.alu_op = 4'b1000;
                6'b101010: dec.alu_op = 4'b0100;
                6'b101011: dec.alu_op = 4'b0101;
                6'b000000: begin dec.alu_op = 4'b1011; dec.src1_shamt = 1'b1; end
                6'b000010: begin dec.alu_op = 4'b1101; dec.src1_shamt = 1'b1; end
                6'b000011: begin dec.alu_op = 4'b1100; dec.src1_shamt = 1'b1; end
                6'b000100: dec.alu_op = 4'b1011;
                6'b000110: dec.alu_op = 4'b1101;
                6'b000111: dec.alu_op = 4'b1100;
                default:   legal = 1'b0;
            endcase
        end else begin
            dec.dest_reg  = rt;
            dec.src2_imm  = 1'b1;
            dec.reg_write = 1'b1;
            case (op)
                6'b001000: begin dec.alu_op = 4'b0000; dec.imm = imm_se; end
                6'b001001: begin dec.alu_op = 4'b0001; dec.imm = imm_se; end
                6'b001010: begin dec.alu_op = 4'b0100; dec.imm = imm_se; end
                6'b001011: begin dec.alu_op = 4'b0101; dec.imm = imm_se; end
                6'b001100: begin dec.alu_op = 4'b0110; dec.imm = imm_ze; end
                6'b001101: begin dec.alu_op = 4'b1001; dec.imm = imm_ze; end
                6'b001110: begin dec.alu_op = 4'b1010; dec.imm = imm_ze; end
                6'b001111: begin dec.alu_op = 4'b0111; dec.imm = imm_ze; end
                6'b100011: begin dec.alu_op = 4'b0001; dec.imm = imm_se; dec.mem_read = 1'b1; end
                6'b101011: begin
                    dec.alu_op    = 4'b0001;
                    dec.imm       = imm_se;
                    dec.mem_write = 1'b1;
                    dec.reg_write = 1'b0;
                end
                default:   legal = 1'b0;
            endcase
        end
        if (!legal) begin
            dec        = '0;
            dec.alu_op = NOP_OP;
`ifdef ALU_DECODE_TRAP_EN
            dec.rsvd   = 1'b1;
`endif
        end
        // Writes to $0 are architecturally discarded; suppress them here so WB needs no check.
        if (dec.dest_reg == 5'd0)
            dec.reg_write = 1'b0;
    end

    assign inReady = !outValid || outReady;
    assign take    = inValid && inReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid    <= 1'b0;
            held        <= '0;
            held.alu_op <= NOP_OP;
        end else if (flush) begin
            outValid <= 1'b0;
        end else if (take) begin
            outValid <= 1'b1;
            held     <= dec;
        end else if (outReady) begin
            outValid <= 1'b0;
        end
    end

    assign aluOp     = held.alu_op;
    assign src1Shamt = held.src1_shamt;
    assign src2Imm   = held.src2_imm;
    assign imm       = held.imm;
    assign destReg   = held.dest_reg;
    assign regWrite  = held.reg_write;
    assign memRead   = held.mem_read;
    assign memWrite  = held.mem_write;
    assign rsvdInstr = held.rsvd;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed bench for alu_op_decoder: hand-computed decode values, handshake stall/replace, flush and illegal slots.
module tb_alu_op_decoder;

    logic        clk = 1'b0;
    logic        rst, flush, inValid, outReady;
    logic [31:0] instr;
    logic        inReady, outValid, src1Shamt, src2Imm, regWrite, memRead, memWrite, rsvdInstr;
    logic [3:0]  aluOp;
    logic [31:0] imm;
    logic [4:0]  destReg;

    int checks   = 0;
    int failures = 0;

    alu_op_decoder dut (
        .clk(clk), .rst(rst), .flush(flush), .inValid(inValid), .inReady(inReady),
        .instr(instr), .outValid(outValid), .outReady(outReady), .aluOp(aluOp),
        .src1Shamt(src1Shamt), .src2Imm(src2Imm), .imm(imm), .destReg(destReg),
        .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite), .rsvdInstr(rsvdInstr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_rsvd;
`ifdef ALU_DECODE_TRAP_EN
        exp_rsvd = 1'b1;
`else
        exp_rsvd = 1'b0;
`endif
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b1; instr = 32'h0;
        tick(); tick();
        chk("rst_outValid", {31'b0, outValid}, 32'd0);
        chk("rst_aluOp", {28'b0, aluOp}, 32'he);
        chk("rst_inReady", {31'b0, inReady}, 32'd1);
        chk("rst_imm", imm, 32'd0);
        chk("rst_regWrite", {31'b0, regWrite}, 32'd0);

        // add $2,$4,$5
        rst = 1'b0; inValid = 1'b1; instr = 32'h00851020;
        tick();
        chk("add_outValid", {31'b0, outValid}, 32'd1);
        chk("add_aluOp", {28'b0, aluOp}, 32'h0);
        chk("add_destReg", {27'b0, destReg}, 32'd2);
        chk("add_regWrite", {31'b0, regWrite}, 32'd1);
        chk("add_src1Shamt", {31'b0, src1Shamt}, 32'd0);
        chk("add_src2Imm", {31'b0, src2Imm}, 32'd0);

        instr = 32'h2003FFFF; // addi $3,$0,-1
        tick();
        chk("addi_imm", imm, 32'hFFFFFFFF);
        chk("addi_aluOp", {28'b0, aluOp}, 32'h0);
        chk("addi_src2Imm", {31'b0, src2Imm}, 32'd1);
        chk("addi_destReg", {27'b0, destReg}, 32'd3);

        instr = 32'h3003FFFF; // andi
        tick();
        chk("andi_imm", imm, 32'h0000FFFF);
        chk("andi_aluOp", {28'b0, aluOp}, 32'h6);

        instr = 32'h00031100; // sll $2,$3,4
        tick();
        chk("sll_aluOp", {28'b0, aluOp}, 32'hb);
        chk("sll_src1Shamt", {31'b0, src1Shamt}, 32'd1);
        chk("sll_destReg", {27'b0, destReg}, 32'd2);

        instr = 32'h00851007; // srav $2,$5,$4
        tick();
        chk("srav_aluOp", {28'b0, aluOp}, 32'hc);
        chk("srav_src1Shamt", {31'b0, src1Shamt}, 32'd0);

        instr = 32'h00000000; // sll $0 -> no write
        tick();
        chk("nop_regWrite", {31'b0, regWrite}, 32'd0);
        chk("nop_aluOp", {28'b0, aluOp}, 32'hb);

        instr = 32'h8C820004; // lw $2,4($4)
        tick();
        chk("lw_aluOp", {28'b0, aluOp}, 32'h1);
        chk("lw_memRead", {31'b0, memRead}, 32'd1);
        chk("lw_regWrite", {31'b0, regWrite}, 32'd1);
        chk("lw_imm", imm, 32'd4);

        outReady = 1'b0; instr = 32'hAC820008; // sw offered while stalled
        #1;
        chk("stall_inReady", {31'b0, inReady}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_outValid", {31'b0, outValid}, 32'd1);
            chk("stall_memRead", {31'b0, memRead}, 32'd1);
            chk("stall_imm", imm, 32'd4);
        end

        outReady = 1'b1;
        #1;
        chk("replace_inReady", {31'b0, inReady}, 32'd1);
        tick();
        chk("sw_outValid", {31'b0, outValid}, 32'd1);
        chk("sw_memWrite", {31'b0, memWrite}, 32'd1);
        chk("sw_regWrite", {31'b0, regWrite}, 32'd0);
        chk("sw_memRead", {31'b0, memRead}, 32'd0);
        chk("sw_imm", imm, 32'd8);

        inValid = 1'b0;
        tick();
        chk("drain_outValid", {31'b0, outValid}, 32'd0);

        flush = 1'b1; inValid = 1'b1; instr = 32'h00851020;
        tick();
        chk("flush_empty_outValid", {31'b0, outValid}, 32'd0);
        flush = 1'b0;
        tick();
        chk("reload_outValid", {31'b0, outValid}, 32'd1);
        outReady = 1'b0; flush = 1'b1;
        tick();
        chk("flush_held_outValid", {31'b0, outValid}, 32'd0);
        flush = 1'b0; outReady = 1'b1;

        instr = 32'hFC000000; // illegal opcode
        tick();
        chk("illop_outValid", {31'b0, outValid}, 32'd1);
        chk("illop_aluOp", {28'b0, aluOp}, 32'he);
        chk("illop_rsvd", {31'b0, rsvdInstr}, {31'b0, exp_rsvd});
        chk("illop_regWrite", {31'b0, regWrite}, 32'd0);
        chk("illop_src2Imm", {31'b0, src2Imm}, 32'd0);

        instr = 32'h0085103F; // illegal funct
        tick();
        chk("illfn_aluOp", {28'b0, aluOp}, 32'he);
        chk("illfn_rsvd", {31'b0, rsvdInstr}, {31'b0, exp_rsvd});
        chk("illfn_regWrite", {31'b0, regWrite}, 32'd0);

        instr = 32'h34A2F00F; // ori $2,$5,0xF00F: legal entry clears rsvd
        tick();
        chk("ori_aluOp", {28'b0, aluOp}, 32'h9);
        chk("ori_imm", imm, 32'h0000F00F);
        chk("ori_rsvd", {31'b0, rsvdInstr}, 32'd0);

        rst = 1'b1; flush = 1'b1;
        tick();
        chk("rst_flush_aluOp", {28'b0, aluOp}, 32'he);
        chk("rst_flush_outValid", {31'b0, outValid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
